// File: rtl/rate_divider.sv
// rate_divider
//   Divides the board clock into a one-clock `tick` pulse at a switch-selected
//   rate. The pulse is the enable for the downstream ripple-enable counter.
//   The switch inputs are asynchronous and are brought into the clock domain
//   through two-flop synchronisers before use.
//
// Ports
//   clock  in   system clock, rising edge active
//   clear  in   asynchronous active-low reset
//   sel    in   [1:0] rate select switches (asynchronous)
//   run    in   count-enable switch, active high (asynchronous)
//   tick   out  registered one-clock pulse, once per selected period
//   count  out  [WIDTH-1:0] live down-counter value
//   rate   out  [1:0] synchronised, currently effective rate select
module rate_divider #(
  parameter int unsigned WIDTH   = 28,
  parameter int unsigned PERIOD1 = 50000000,
  parameter int unsigned PERIOD2 = 100000000,
  parameter int unsigned PERIOD3 = 200000000
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [1:0]       sel,
  input  logic             run,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       rate
);

  // Reload values are period-1 so that ticks land exactly P clocks apart.
  localparam logic [WIDTH-1:0] RELOAD1 = WIDTH'(PERIOD1 - 1);
  localparam logic [WIDTH-1:0] RELOAD2 = WIDTH'(PERIOD2 - 1);
  localparam logic [WIDTH-1:0] RELOAD3 = WIDTH'(PERIOD3 - 1);

  logic [1:0]       sel_meta_q;
  logic [1:0]       sel_s_q;
  logic [1:0]       sel_prev_q;
  logic             run_meta_q;
  logic             run_s_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] reload;

  // Synchronisers and edge-detect history for the switch inputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sel_meta_q <= '0;
      sel_s_q    <= '0;
      sel_prev_q <= '0;
      run_meta_q <= 1'b0;
      run_s_q    <= 1'b0;
    end else begin
      sel_meta_q <= sel;
      sel_s_q    <= sel_meta_q;
      sel_prev_q <= sel_s_q;
      run_meta_q <= run;
      run_s_q    <= run_meta_q;
    end
  end

  // Period-1 for the effective rate; sel=00 reloads 0 so a tick fires every
  // clock while running.
  always_comb begin
    reload = '0;
    case (sel_s_q)
      2'b01:   reload = RELOAD1;
      2'b10:   reload = RELOAD2;
      2'b11:   reload = RELOAD3;
      default: reload = '0;
    endcase
  end

  // Priority: rate change, then pause, then reload-with-tick, then decrement.
  // A rate change always restarts the period and suppresses the tick, even
  // when it coincides with count reaching zero.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (sel_s_q != sel_prev_q) begin
      count_d = reload;
    end else if (!run_s_q) begin
      count_d = count_q;
    end else if (count_q == '0) begin
      tick_d  = 1'b1;
      count_d = reload;
    end else begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign count = count_q;
  assign rate  = sel_s_q;

endmodule

// File: tb/tb_rate_divider.sv
// Testbench for rate_divider with WIDTH=5, periods 4/8/16.
module tb_rate_divider;

  localparam int W = 5;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic [1:0]   sel   = 2'b00;
  logic         run   = 1'b0;
  logic         tick;
  logic [W-1:0] count;
  logic [1:0]   rate;

  rate_divider #(
    .WIDTH  (W),
    .PERIOD1(4),
    .PERIOD2(8),
    .PERIOD3(16)
  ) dut (
    .clock(clock),
    .clear(clear),
    .sel  (sel),
    .run  (run),
    .tick (tick),
    .count(count),
    .rate (rate)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic         tick;
    logic [W-1:0] count;
    logic [1:0]   rate;
  } exp_t;

  exp_t sb[$];
  int   tick_times[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Switch views are the pin values sampled two edges earlier. The divider is
  // tracked as the phase within the current period: count = P-1-phase.
  logic [1:0] sel_hist[$];
  logic       run_hist[$];
  logic [1:0] m_prev_eff;
  int         m_phase;
  logic       m_tick;

  function automatic int period(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 4;
      2'd2:    return 8;
      default: return 16;
    endcase
  endfunction

  task automatic model_reset();
    sel_hist   = '{2'b00, 2'b00};
    run_hist   = '{1'b0, 1'b0};
    m_prev_eff = 2'b00;
    m_phase    = 0;
    m_tick     = 1'b0;
  endtask

  initial model_reset();
  always @(negedge clear) model_reset();

  always @(posedge clock) begin
    logic [1:0] eff_sel;
    logic       eff_run;
    int         p;
    cyc++;
    if (!clear) begin
      model_reset();
      sb.push_back('{tick: 1'b0, count: '0, rate: 2'b00});
    end else begin
      eff_sel = sel_hist[0];
      eff_run = run_hist[0];
      p       = period(eff_sel);
      if (eff_sel != m_prev_eff) begin
        m_phase = 0;
        m_tick  = 1'b0;
      end else if (!eff_run) begin
        m_tick = 1'b0;
      end else if (m_phase == p - 1) begin
        m_phase = 0;
        m_tick  = 1'b1;
      end else begin
        m_phase = m_phase + 1;
        m_tick  = 1'b0;
      end
      m_prev_eff = eff_sel;
      sel_hist.push_back(sel);
      void'(sel_hist.pop_front());
      run_hist.push_back(run);
      void'(run_hist.pop_front());
      sb.push_back('{tick: m_tick, count: W'(p - 1 - m_phase), rate: sel_hist[0]});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_tick",  32'(tick),  32'(e.tick));
      check("sb_count", 32'(count), 32'(e.count));
      check("sb_rate",  32'(rate),  32'(e.rate));
    end
    if (tick) tick_times.push_back(cyc);
  end

  // ---------------- stimulus ----------------
  task automatic wait_count(input int v, input int budget, input string name);
    int n;
    n = 0;
    while (count != W'(v) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(count), 32'(v));
  endtask

  task automatic check_spacing(input string name, input int n_exp, input int gap);
    check({name, "_n"}, 32'(tick_times.size()), 32'(n_exp));
    for (int i = 1; i < tick_times.size(); i++)
      check({name, "_gap"}, 32'(tick_times[i] - tick_times[i-1]), 32'(gap));
  endtask

  initial begin
    int c0;

    // 1: sel=00, run=1, tick every clock from edge 3
    sel = 2'b00; run = 1'b1;
    repeat (3) @(negedge clock);
    check("t1_reset_tick",  32'(tick),  0);
    check("t1_reset_count", 32'(count), 0);
    clear = 1'b1;
    repeat (2) @(negedge clock);
    check("t1_tick_e2", 32'(tick), 0);
    @(negedge clock);
    check("t1_tick_e3", 32'(tick), 1);
    repeat (5) @(negedge clock);
    check("t1_tick_hold", 32'(tick), 1);
    check("t1_count0",    32'(count), 0);

    // 2: sel=01, period 4
    sel = 2'b01;
    repeat (3) @(negedge clock);
    check("t2_reload_count", 32'(count), 3);
    check("t2_reload_tick",  32'(tick), 0);
    #1 tick_times.delete();
    repeat (16) @(negedge clock);
    #1 check_spacing("t2", 4, 4);

    // 3: pause for 5 clocks, count holds at 2, interval stretches to 9
    @(negedge clock);
    wait_count(0, 10, "t3_find0");
    #1 tick_times.delete();
    run = 1'b0;
    repeat (3) @(negedge clock);
    check("t3_hold_a", 32'(count), 2);
    repeat (2) @(negedge clock);
    run = 1'b1;
    repeat (2) @(negedge clock);
    check("t3_hold_b", 32'(count), 2);
    repeat (6) @(negedge clock);
    #1 check_spacing("t3", 2, 9);

    // 4: rate change coinciding with count==0
    @(negedge clock);
    wait_count(2, 10, "t4_find2");
    #1 sel = 2'b11;
    tick_times.delete();
    repeat (3) @(negedge clock);
    check("t4_count15", 32'(count), 15);
    check("t4_notick",  32'(tick), 0);
    check("t4_rate",    32'(rate), 3);
    c0 = cyc;
    repeat (17) @(negedge clock);
    #1 check("t4_ntick", 32'(tick_times.size()), 1);
    if (tick_times.size() > 0)
      check("t4_gap", 32'(tick_times[0] - c0), 16);

    // 5: asynchronous clear mid-count
    @(negedge clock);
    wait_count(9, 20, "t5_find9");
    #2 clear = 1'b0;
    #1;
    check("t5_count", 32'(count), 0);
    check("t5_tick",  32'(tick), 0);
    check("t5_rate",  32'(rate), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t5_hold_count", 32'(count), 0);
      check("t5_hold_rate",  32'(rate), 0);
    end
    clear = 1'b1;

    // 6: sel=10 for 64 clocks
    sel = 2'b10; run = 1'b1;
    repeat (6) @(negedge clock);
    #1 tick_times.delete();
    repeat (64) @(negedge clock);
    #1 check_spacing("t6", 8, 8);

    // random phase
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom);
      run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 clear = 1'b0;
        #1 check("rnd_clear_count", 32'(count), 0);
        @(negedge clock);
        clear = 1'b1;
      end
    end

    repeat (3) @(negedge clock);
    #1 check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
